// File: rtl/fp16_mult_result_queue.sv
// fp16_mult_result_queue
// Result buffer behind the half-precision multiplier. Each accepted product is
// classified (zero / subnormal / inf / qnan / snan) and stored with its class
// in a first-word-fall-through FIFO toward the writeback consumer. Sticky
// exception flags accumulate the classes of every accepted product until
// cleared.
//
// Build option: define FP16_FTZ_EN to flush subnormal products to signed zero
// at push time. The flush is recorded as zero|subnormal in the stored flags.
// Without the macro, products are stored bit-exact.

module fp16_mult_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [15:0]      in_product,
    output logic             in_ready,
    output logic             out_valid,
    output logic [15:0]      out_product,
    output logic [4:0]       out_flags,
    input  logic             out_ready,
    input  logic             flag_clear,
    output logic [4:0]       sticky_flags,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Class bit positions in the 5-bit flag vector.
    localparam int F_ZERO = 0;
    localparam int F_SUB  = 1;
    localparam int F_INF  = 2;
    localparam int F_QNAN = 3;
    localparam int F_SNAN = 4;

    typedef struct packed {
        logic [4:0]  flags;
        logic [15:0] product;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       sticky_q, sticky_d;

    logic             push;
    logic             pop;
    entry_t           new_entry;
    logic [4:0]       exp_w;
    logic [9:0]       mant_w;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign exp_w  = in_product[14:10];
    assign mant_w = in_product[9:0];

    // Classify the incoming product and form the entry to be stored.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        new_entry.flags   = '0;
        new_entry.product = in_product;
        if (exp_w == 5'h00) begin
            if (mant_w == 10'h000) begin
                new_entry.flags[F_ZERO] = 1'b1;
            end else begin
`ifdef FP16_FTZ_EN
                new_entry.flags[F_ZERO] = 1'b1;
                new_entry.flags[F_SUB]  = 1'b1;
                new_entry.product       = {in_product[15], 15'b0};
`else
                new_entry.flags[F_SUB]  = 1'b1;
`endif
            end
        end else if (exp_w == 5'h1F) begin
            if (mant_w == 10'h000) begin
                new_entry.flags[F_INF] = 1'b1;
            end else if (mant_w[9]) begin
                new_entry.flags[F_QNAN] = 1'b1;
            end else begin
                new_entry.flags[F_SNAN] = 1'b1;
            end
        end
    end

    // Next-state for pointers, occupancy and sticky flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A set in the same cycle as a clear survives the clear.
        sticky_d = (flag_clear ? 5'b0 : sticky_q) | (push ? new_entry.flags : 5'b0);
    end

    // Control state register with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge value of its inputs.
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    // Entry storage; written on push only.
    always_ff @(posedge CLK) begin
        // NOTE: storage is deliberately not reset; stale entries are hidden
        // because the head outputs are masked while the queue is empty.
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    assign out_product  = out_valid ? mem_q[rd_ptr_q].product : 16'h0000;
    assign out_flags    = out_valid ? mem_q[rd_ptr_q].flags   : 5'h00;
    assign sticky_flags = sticky_q;
    assign count        = count_q;

endmodule

// File: tb/tb_fp16_mult_result_queue.sv
// Testbench for fp16_mult_result_queue: directed stimulus with a scoreboard
// queue of expected head entries, checked by an independent output monitor.

module tb_fp16_mult_result_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             CLK = 1'b0;
    logic             RST;
    logic             in_valid;
    logic [15:0]      in_product;
    logic             in_ready;
    logic             out_valid;
    logic [15:0]      out_product;
    logic [4:0]       out_flags;
    logic             out_ready;
    logic             flag_clear;
    logic [4:0]       sticky_flags;
    logic [CNT_W-1:0] count;

    int checks   = 0;
    int failures = 0;

    // Expected head entries {flags, product}, oldest first.
    logic [20:0] sb[$];

    fp16_mult_result_queue #(.DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_product   (in_product),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_product  (out_product),
        .out_flags    (out_flags),
        .out_ready    (out_ready),
        .flag_clear   (flag_clear),
        .sticky_flags (sticky_flags),
        .count        (count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present one product for one cycle; record it when it is expected to land.
    task automatic push(input logic [15:0] prod, input logic [4:0] flags, input bit accept);
        in_valid   = 1'b1;
        in_product = prod;
        if (accept) sb.push_back({flags, prod});
        step();
        in_valid   = 1'b0;
    endtask

    // Drain with out_ready high, bounded.
    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while (count != 0 && n < 20) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        check(name, 32'(count), 32'd0);
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    // Monitor: compare every popped head against the scoreboard.
    always @(negedge CLK) begin
        if (!RST && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got 0x%0h with flags 0x%0h, expected nothing", out_product, out_flags);
            end else begin
                logic [20:0] e;
                e = sb.pop_front();
                check("pop_product", 32'(out_product), 32'(e[15:0]));
                check("pop_flags",   32'(out_flags),   32'(e[20:16]));
            end
        end
    end

    logic [4:0] sub_flags;
    logic [15:0] sub_prod;
    logic [4:0] sticky_exp;

    initial begin
`ifdef FP16_FTZ_EN
        sub_flags  = 5'h03;
        sub_prod   = 16'h0000;
        sticky_exp = 5'h1F;
`else
        sub_flags  = 5'h02;
        sub_prod   = 16'h0001;
        sticky_exp = 5'h1E;
`endif
        RST        = 1'b1;
        in_valid   = 1'b0;
        in_product = 16'h0000;
        out_ready  = 1'b0;
        flag_clear = 1'b0;
        step();
        step();
        RST = 1'b0;
        step();

        // Reset state.
        check("rst_count",     32'(count),        32'd0);
        check("rst_in_ready",  32'(in_ready),     32'd1);
        check("rst_out_valid", 32'(out_valid),    32'd0);
        check("rst_out_prod",  32'(out_product),  32'd0);
        check("rst_out_flags", 32'(out_flags),    32'd0);
        check("rst_sticky",    32'(sticky_flags), 32'd0);

        // Normals, popped in order.
        push(16'h3C00, 5'h00, 1'b1);
        check("fwft_valid", 32'(out_valid),   32'd1);
        check("fwft_head",  32'(out_product), 32'h3C00);
        push(16'h4000, 5'h00, 1'b1);
        push(16'hC200, 5'h00, 1'b1);
        check("n3_count",    32'(count),    32'd3);
        check("n3_in_ready", 32'(in_ready), 32'd1);
        drain("n3_drain");
        check("n3_sticky", 32'(sticky_flags), 32'd0);

        // Special classes; fills the queue.
        push(16'h7E00, 5'h08, 1'b1);
        push(16'h7D00, 5'h10, 1'b1);
        push(16'h7C00, 5'h04, 1'b1);
        push(16'h0001, sub_flags, 1'b1);
        if (sub_prod == 16'h0000) sb[3][15:0] = sub_prod;
        check("cls_sticky",     32'(sticky_flags), 32'(sticky_exp));
        check("full_count",     32'(count),        32'd4);
        check("full_in_ready",  32'(in_ready),     32'd0);

        // Push while full is dropped.
        push(16'h1234, 5'h00, 1'b0);
        check("drop_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pop1_count", 32'(count), 32'd3);
        push(16'h3C00, 5'h00, 1'b1);
        drain("full_drain");

        // Simultaneous push/pop across pointer wrap.
        push(16'h3800, 5'h00, 1'b1);
        push(16'h3400, 5'h00, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(16'h4400 + 16'(i * 16'h0100), 5'h00, 1'b1);
            check("stream_count", 32'(count), 32'd2);
        end
        drain("stream_drain");

        // Set wins over clear; signed zero classified as zero.
        out_ready  = 1'b1;
        flag_clear = 1'b1;
        push(16'h8000, 5'h01, 1'b1);
        flag_clear = 1'b0;
        check("clr_set_sticky", 32'(sticky_flags), 32'h01);
        flag_clear = 1'b1;
        step();
        flag_clear = 1'b0;
        check("clr_sticky", 32'(sticky_flags), 32'h00);
        drain("clr_drain");

        // Reset mid-operation.
        push(16'h3C00, 5'h00, 1'b1);
        push(16'h7C00, 5'h04, 1'b1);
        push(16'h4200, 5'h00, 1'b1);
        check("pre_rst_count",  32'(count),        32'd3);
        check("pre_rst_sticky", 32'(sticky_flags), 32'h04);
        RST = 1'b1;
        sb.delete();
        step();
        RST = 1'b0;
        check("mid_rst_count",     32'(count),        32'd0);
        check("mid_rst_out_valid", 32'(out_valid),    32'd0);
        check("mid_rst_out_prod",  32'(out_product),  32'd0);
        check("mid_rst_sticky",    32'(sticky_flags), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),     32'd1);

        // Queue usable after reset.
        push(16'hBC00, 5'h00, 1'b1);
        drain("post_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
